// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//   Shares the single RegFile write port between the ALU (source A) and the
//   LSU (source B) writeback buses using round-robin arbitration with
//   valid/ready handshakes. The accepted write is presented to the RegFile one
//   cycle later from registered outputs. A per-register busy scoreboard lets
//   the issue stage stall on read-after-write hazards.
//
//   Ports
//     clk, rst_n              clock (rising edge), async active-low reset
//     a_valid/a_addr/a_data   ALU writeback request
//     a_ready                 ALU request accepted this cycle (combinational)
//     b_valid/b_addr/b_data   LSU writeback request
//     b_ready                 LSU request accepted this cycle (combinational)
//     iss_valid/iss_addr      issue stage marks a destination register busy
//     q_addr1/q_addr2         hazard query addresses
//     q_busy1/q_busy2         pending-write flags for the queried registers
//     rf_wen/rf_waddr/rf_wdata  registered RegFile write port
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_addr,
    input  logic [ADDR_WIDTH-1:0] q_addr1,
    input  logic [ADDR_WIDTH-1:0] q_addr2,
    output logic                  q_busy1,
    output logic                  q_busy2,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int NREG = 2 ** ADDR_WIDTH;

    // Priority pointer: 0 = A wins a tie, 1 = B wins a tie.
    logic            ptr_b_r;
    logic            grant_a_s;
    logic            grant_b_s;
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;

    // Round-robin grant; both readies are held low while reset is asserted.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (!rst_n) begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else if (a_valid && b_valid) begin
            grant_a_s = ~ptr_b_r;
            grant_b_s = ptr_b_r;
        end else begin
            grant_a_s = a_valid;
            grant_b_s = b_valid;
        end
    end

    assign a_ready = grant_a_s;
    assign b_ready = grant_b_s;

    // Pointer flips to the other source after every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_b_r <= 1'b0;
        end else if (grant_a_s) begin
            ptr_b_r <= 1'b1;
        end else if (grant_b_s) begin
            ptr_b_r <= 1'b0;
        end else begin
            ptr_b_r <= ptr_b_r;
        end
    end

    // Registered RegFile write port; x0 handshakes complete without a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant_a_s) begin
            rf_wen   <= (a_addr != '0);
            rf_waddr <= a_addr;
            rf_wdata <= a_data;
        end else if (grant_b_s) begin
            rf_wen   <= (b_addr != '0);
            rf_waddr <= b_addr;
            rf_wdata <= b_data;
        end else begin
            rf_wen   <= 1'b0;
            rf_waddr <= rf_waddr;
            rf_wdata <= rf_wdata;
        end
    end

    // Scoreboard next state: clear on commit first so a same-edge set wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (rf_wen) begin
            busy_nxt_s[rf_waddr] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (iss_valid && (iss_addr != '0)) begin
            busy_nxt_s[iss_addr] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Hazard queries read state only; no same-cycle forwarding.
    assign q_busy1 = busy_r[q_addr1];
    assign q_busy2 = busy_r[q_addr2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, b_valid, a_ready, b_ready;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          iss_valid;
    logic [AW-1:0] iss_addr, q_addr1, q_addr2;
    logic          q_busy1, q_busy2;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .q_addr1(q_addr1), .q_addr2(q_addr2),
        .q_busy1(q_busy1), .q_busy2(q_busy2),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
    typedef struct packed { logic wen; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;

    req_t         a_q[$];
    req_t         b_q[$];
    wr_t          sb_q[$];
    logic         m_ptr_b;
    logic [31:0]  m_busy;
    int           checks = 0;
    int           failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_ptr_b = 1'b0;
        m_busy  = '0;
    endtask

    // Present the head of each request list; a held request stays unchanged.
    task automatic drive_from_lists();
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        if (a_q.size() > 0) begin
            a_valid = 1'b1; a_addr = a_q[0].addr; a_data = a_q[0].data;
        end
        if (b_q.size() > 0) begin
            b_valid = 1'b1; b_addr = b_q[0].addr; b_data = b_q[0].data;
        end
    endtask

    // One clock: check at negedge against the model, advance model, step edge.
    task automatic cycle();
        logic ga, gb;
        wr_t  cur, nxt;
        @(negedge clk);
        if (a_valid && b_valid) begin
            ga = ~m_ptr_b; gb = m_ptr_b;
        end else begin
            ga = a_valid; gb = b_valid;
        end
        check_eq("a_ready", 64'(a_ready), 64'(ga));
        check_eq("b_ready", 64'(b_ready), 64'(gb));
        if (sb_q.size() > 0) cur = sb_q.pop_front();
        else cur = '0;
        check_eq("rf_wen", 64'(rf_wen), 64'(cur.wen));
        if (cur.wen) begin
            check_eq("rf_waddr", 64'(rf_waddr), 64'(cur.addr));
            check_eq("rf_wdata", 64'(rf_wdata), 64'(cur.data));
        end
        check_eq("q_busy1", 64'(q_busy1), 64'(m_busy[q_addr1]));
        check_eq("q_busy2", 64'(q_busy2), 64'(m_busy[q_addr2]));
        if (cur.wen) m_busy[cur.addr] = 1'b0;
        if (iss_valid && iss_addr != '0) m_busy[iss_addr] = 1'b1;
        nxt = '0;
        if (ga) begin
            nxt.wen = (a_addr != '0); nxt.addr = a_addr; nxt.data = a_data;
            void'(a_q.pop_front());
            m_ptr_b = 1'b1;
        end else if (gb) begin
            nxt.wen = (b_addr != '0); nxt.addr = b_addr; nxt.data = b_data;
            void'(b_q.pop_front());
            m_ptr_b = 1'b0;
        end
        sb_q.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    // Drain both lists (bounded), then run some idle cycles.
    task automatic run_lists(input int extra, input bit rnd);
        int n = 0;
        while ((a_q.size() > 0 || b_q.size() > 0) && n < 200) begin
            drive_from_lists();
            if (rnd) begin
                iss_valid = 1'($urandom_range(0, 1));
                iss_addr  = AW'($urandom);
                q_addr1   = AW'($urandom);
                q_addr2   = AW'($urandom);
            end
            cycle();
            n++;
        end
        check_eq("drain_timeout", 64'(a_q.size() + b_q.size()), 64'd0);
        iss_valid = 1'b0;
        for (int i = 0; i < extra; i++) begin
            drive_from_lists();
            cycle();
        end
    endtask

    initial begin
        req_t r;
        rst_n = 1'b0; iss_valid = 1'b0; iss_addr = '0; q_addr1 = '0; q_addr2 = '0;
        model_reset();

        // Reset with both sources requesting; then round-robin A,B,A,B.
        a_q.push_back('{addr: 5'd1, data: 32'h1111_0001});
        a_q.push_back('{addr: 5'd2, data: 32'h1111_0002});
        b_q.push_back('{addr: 5'd3, data: 32'h2222_0003});
        b_q.push_back('{addr: 5'd4, data: 32'h2222_0004});
        drive_from_lists();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_a_ready", 64'(a_ready), 64'd0);
            check_eq("rst_b_ready", 64'(b_ready), 64'd0);
            check_eq("rst_rf_wen", 64'(rf_wen), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        drive_from_lists();
        #1;
        check_eq("first_grant_a", 64'(a_ready), 64'd1);
        run_lists(1, 1'b0);

        // Single ALU write, latency one cycle.
        a_q.push_back('{addr: 5'd5, data: 32'hDEAD_BEEF});
        run_lists(2, 1'b0);

        // Scoreboard set, then clear on commit.
        iss_valid = 1'b1; iss_addr = 5'd7; q_addr1 = 5'd7;
        drive_from_lists();
        cycle();
        iss_valid = 1'b0;
        check_eq("busy7_set", 64'(q_busy1), 64'd1);
        b_q.push_back('{addr: 5'd7, data: 32'h0000_7777});
        run_lists(2, 1'b0);
        check_eq("busy7_clr", 64'(q_busy1), 64'd0);

        // Same-edge set and clear on addr 9: set wins.
        iss_valid = 1'b1; iss_addr = 5'd9;
        drive_from_lists();
        cycle();
        iss_valid = 1'b0;
        a_q.push_back('{addr: 5'd9, data: 32'h0000_0009});
        drive_from_lists();
        cycle();
        drive_from_lists();
        iss_valid = 1'b1; iss_addr = 5'd9; q_addr1 = 5'd9;
        cycle();
        iss_valid = 1'b0;
        check_eq("busy9_set_wins", 64'(q_busy1), 64'd1);

        // Write to x0: handshake completes, no RegFile write, never busy.
        a_q.push_back('{addr: 5'd0, data: 32'h0000_1234});
        iss_valid = 1'b1; iss_addr = 5'd0; q_addr2 = 5'd0;
        drive_from_lists();
        cycle();
        iss_valid = 1'b0;
        check_eq("x0_rf_wen", 64'(rf_wen), 64'd0);
        check_eq("x0_busy", 64'(q_busy2), 64'd0);
        drive_from_lists();
        cycle();

        // Random mixed traffic with random issue and queries.
        for (int i = 0; i < 12; i++) begin
            r.addr = AW'($urandom); r.data = $urandom; a_q.push_back(r);
            r.addr = AW'($urandom); r.data = $urandom; b_q.push_back(r);
        end
        run_lists(3, 1'b1);

        // Reset while a write is pending and register 3 is busy.
        iss_valid = 1'b1; iss_addr = 5'd3; q_addr1 = 5'd3;
        drive_from_lists();
        cycle();
        iss_valid = 1'b0;
        a_q.push_back('{addr: 5'd3, data: 32'h00C0_FFEE});
        drive_from_lists();
        cycle();
        check_eq("pre_rst_wen", 64'(rf_wen), 64'd1);
        check_eq("pre_rst_busy3", 64'(q_busy1), 64'd1);
        a_valid = 1'b1; b_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_rf_wen", 64'(rf_wen), 64'd0);
        check_eq("midrst_busy3", 64'(q_busy1), 64'd0);
        check_eq("midrst_a_ready", 64'(a_ready), 64'd0);
        check_eq("midrst_b_ready", 64'(b_ready), 64'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_from_lists();
        run_lists(2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
